// File: rtl/nanolada_pkg.sv
// Shared nanoLADA definitions: ALU opcodes and the multiplier controller state encoding.
package nanolada_pkg;

    localparam int unsigned ALU_OP_W = 3;
    localparam int unsigned MUL_CNT_W = 5;

    localparam logic [ALU_OP_W-1:0] ALU_ADD  = 3'b000;
    localparam logic [ALU_OP_W-1:0] ALU_SUB  = 3'b001;
    localparam logic [ALU_OP_W-1:0] ALU_OR   = 3'b010;
    localparam logic [ALU_OP_W-1:0] ALU_AND  = 3'b011;
    localparam logic [ALU_OP_W-1:0] ALU_XOR  = 3'b100;
    localparam logic [ALU_OP_W-1:0] ALU_NEG  = 3'b101;
    localparam logic [ALU_OP_W-1:0] ALU_NOTA = 3'b110;
    localparam logic [ALU_OP_W-1:0] ALU_NOTB = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_e;

endpackage

// File: rtl/alu.sv
// Shared combinational ALU; the multiplier controller borrows its adder.
module alu
    import nanolada_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0]     a,
    input  logic [XLEN-1:0]     b,
    input  logic                cin,
    input  logic [ALU_OP_W-1:0] ops,
    output logic [XLEN-1:0]     s,
    output logic                cout
);

    always_comb begin
        s    = '0;
        cout = 1'b0;
        case (ops)
            ALU_ADD:  {cout, s} = {1'b0, a} + {1'b0, b} + (XLEN+1)'(cin);
            ALU_SUB:  {cout, s} = {1'b0, a} + {1'b0, ~b} + (XLEN+1)'(1);
            ALU_OR:   s = a | b;
            ALU_AND:  s = a & b;
            ALU_XOR:  s = a ^ b;
            ALU_NEG:  s = XLEN'(~a + XLEN'(1));
            ALU_NOTA: s = ~a;
            ALU_NOTB: s = ~b;
            default:  s = '0;
        endcase
    end

endmodule

// File: rtl/mul_seq.sv
// Sequential unsigned shift-add multiplier controller; one add per cycle via the shared ALU.
module mul_seq
    import nanolada_pkg::*;
#(
    parameter bit          EARLY_ZERO = 1'b1,
    parameter int unsigned XLEN       = 32
) (
    input  logic                clk,
    input  logic                nreset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [XLEN-1:0]     req_a,
    input  logic [XLEN-1:0]     req_b,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [XLEN-1:0]     rsp_hi,
    output logic [XLEN-1:0]     rsp_lo,
    output logic [XLEN-1:0]     alu_a,
    output logic [XLEN-1:0]     alu_b,
    output logic                alu_cin,
    output logic [ALU_OP_W-1:0] alu_ops,
    input  logic [XLEN-1:0]     alu_s,
    input  logic                alu_cout
);

    localparam logic [MUL_CNT_W-1:0] CNT_LAST = MUL_CNT_W'(XLEN - 1);

    mul_state_e           state_q, state_d;
    logic [MUL_CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]      p_hi_q, p_hi_d;
    logic [XLEN-1:0]      p_lo_q, p_lo_d;
    logic [XLEN-1:0]      m_q, m_d;

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            p_hi_q  <= '0;
            p_lo_q  <= '0;
            m_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            p_hi_q  <= p_hi_d;
            p_lo_q  <= p_lo_d;
            m_q     <= m_d;
        end
    end

    // Next state and datapath; the 33-bit {cout,sum} is shifted right so nothing overflows.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        p_hi_d  = p_hi_q;
        p_lo_d  = p_lo_q;
        m_d     = m_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    m_d    = req_a;
                    p_lo_d = req_b;
                    p_hi_d = '0;
                    cnt_d  = '0;
                    if (EARLY_ZERO && ((req_a == '0) || (req_b == '0))) begin
                        p_lo_d  = '0;
                        state_d = DONE;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (p_lo_q[0]) begin
                    {p_hi_d, p_lo_d} = {alu_cout, alu_s, p_lo_q[XLEN-1:1]};
                end else begin
                    {p_hi_d, p_lo_d} = {1'b0, p_hi_q, p_lo_q[XLEN-1:1]};
                end
                cnt_d = cnt_q + MUL_CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake and ALU drive decode registered state only.
    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        alu_a     = '0;
        alu_b     = '0;
        alu_cin   = 1'b0;
        alu_ops   = ALU_ADD;
        case (state_q)
            IDLE: req_ready = 1'b1;
            RUN: begin
                alu_a = p_hi_q;
                alu_b = m_q;
            end
            DONE: rsp_valid = 1'b1;
            default: ;
        endcase
    end

    assign rsp_hi = p_hi_q;
    assign rsp_lo = p_lo_q;

endmodule

// File: tb/tb_mul_seq.sv
// Directed bench for mul_seq with the shared alu; two instances cover EARLY_ZERO on and off.
module tb_mul_seq;

    logic        clk = 1'b0;
    logic        nreset;
    logic        req_valid;
    logic        rsp_ready;
    logic        sel;
    logic [31:0] req_a;
    logic [31:0] req_b;

    logic        req_ready0, rsp_valid0, alu_cin0, alu_cout0;
    logic [31:0] rsp_hi0, rsp_lo0, alu_a0, alu_b0, alu_s0;
    logic [2:0]  alu_ops0;
    logic        req_ready1, rsp_valid1, alu_cin1, alu_cout1;
    logic [31:0] rsp_hi1, rsp_lo1, alu_a1, alu_b1, alu_s1;
    logic [2:0]  alu_ops1;

    logic        obs_req_ready, obs_rsp_valid;
    logic [31:0] obs_hi, obs_lo;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    mul_seq #(.EARLY_ZERO(1'b1)) u_dut0 (
        .clk(clk), .nreset(nreset),
        .req_valid(req_valid & ~sel), .req_ready(req_ready0),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready),
        .rsp_hi(rsp_hi0), .rsp_lo(rsp_lo0),
        .alu_a(alu_a0), .alu_b(alu_b0), .alu_cin(alu_cin0), .alu_ops(alu_ops0),
        .alu_s(alu_s0), .alu_cout(alu_cout0)
    );

    alu u_alu0 (
        .a(alu_a0), .b(alu_b0), .cin(alu_cin0), .ops(alu_ops0),
        .s(alu_s0), .cout(alu_cout0)
    );

    mul_seq #(.EARLY_ZERO(1'b0)) u_dut1 (
        .clk(clk), .nreset(nreset),
        .req_valid(req_valid & sel), .req_ready(req_ready1),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready),
        .rsp_hi(rsp_hi1), .rsp_lo(rsp_lo1),
        .alu_a(alu_a1), .alu_b(alu_b1), .alu_cin(alu_cin1), .alu_ops(alu_ops1),
        .alu_s(alu_s1), .alu_cout(alu_cout1)
    );

    alu u_alu1 (
        .a(alu_a1), .b(alu_b1), .cin(alu_cin1), .ops(alu_ops1),
        .s(alu_s1), .cout(alu_cout1)
    );

    assign obs_req_ready = sel ? req_ready1 : req_ready0;
    assign obs_rsp_valid = sel ? rsp_valid1 : rsp_valid0;
    assign obs_hi        = sel ? rsp_hi1    : rsp_hi0;
    assign obs_lo        = sel ? rsp_lo1    : rsp_lo0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // One transaction: accept, count cycles to rsp_valid, optionally stall, then retire.
    task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input int exp_lat, input int hold);
        int cyc;
        check({tag, " ready_before"}, 64'(obs_req_ready), 64'd1);
        req_a     = a;
        req_b     = b;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_a     = 32'hDEAD_BEEF;
        req_b     = 32'hFFFF_FFFF;
        cyc = 0;
        while (!obs_rsp_valid && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, " latency"}, 64'(cyc), 64'(exp_lat));
        check({tag, " product"}, {obs_hi, obs_lo}, exp);
        check({tag, " busy_ready"}, 64'(obs_req_ready), 64'd0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, " stall_valid_ready"}, 64'({obs_rsp_valid, obs_req_ready}), 64'b10);
            check({tag, " stall_product"}, {obs_hi, obs_lo}, exp);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check({tag, " idle_valid_ready"}, 64'({obs_rsp_valid, obs_req_ready}), 64'b01);
        check({tag, " product_kept"}, {obs_hi, obs_lo}, exp);
    endtask

    initial begin
        nreset    = 1'b0;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        sel       = 1'b0;
        req_a     = '0;
        req_b     = '0;
        repeat (2) @(negedge clk);

        check("reset_valid_ready", 64'({rsp_valid0, req_ready0}), 64'b01);
        check("reset_product", {rsp_hi0, rsp_lo0}, 64'd0);
        check("reset_alu_drive", {alu_a0, alu_b0}, 64'd0);
        check("reset_alu_op", 64'({alu_cin0, alu_ops0}), 64'd0);
        nreset = 1'b1;
        @(negedge clk);

        do_op("3x5", 32'd3, 32'd5, 64'h0000_0000_0000_000F, 32, 0);
        do_op("ffxff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 32, 0);
        do_op("msbx2", 32'h8000_0000, 32'h0000_0002, 64'h0000_0001_0000_0000, 32, 0);
        do_op("zero_a_ez1", 32'd0, 32'h0000_1234, 64'd0, 0, 0);
        do_op("zero_b_ez1", 32'h0000_1234, 32'd0, 64'd0, 0, 0);
        do_op("backpressure", 32'h0000_FFFF, 32'h0000_FFFF, 64'h0000_0000_FFFE_0001, 32, 5);

        sel = 1'b1;
        @(negedge clk);
        do_op("zero_a_ez0", 32'd0, 32'h0000_1234, 64'd0, 32, 0);
        sel = 1'b0;
        @(negedge clk);

        // Abort an op while RUN holds cnt=10.
        req_a     = 32'd3;
        req_b     = 32'd5;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (10) @(negedge clk);
        check("midop_running", 64'({rsp_valid0, req_ready0}), 64'b00);
        check("midop_alu_op", 64'({alu_cin0, alu_ops0}), 64'd0);
        nreset = 1'b0;
        @(negedge clk);
        check("midop_reset_valid_ready", 64'({rsp_valid0, req_ready0}), 64'b01);
        check("midop_reset_product", {rsp_hi0, rsp_lo0}, 64'd0);
        nreset = 1'b1;
        @(negedge clk);
        do_op("7x9", 32'd7, 32'd9, 64'd63, 32, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
